// File: rtl/div_mon_pkg.sv
// rtl/div_mon_pkg.sv - shared state codes and default constants for the divided-clock monitor
package div_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_FAULT   = 2'd3
  } mon_state_t;

  localparam int WIN_CYCLES_DEF = 56;
  localparam int EXP_EDGES_DEF  = 16;
  localparam int TOL_DEF        = 1;
  localparam int LOCK_WINS_DEF  = 4;

endpackage

// File: rtl/clk_edge_sync.sv
// rtl/clk_edge_sync.sv - two-flop synchronizer plus history flop giving a rising-edge strobe
module clk_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  input  logic load_hist,
  input  logic track,
  output logic rise
);

  logic sync_q1;
  logic sync_q2;
  logic hist;

  // hist freezes while the monitor is idle and is reloaded on entry, so a
  // level that is already high is not mistaken for a fresh edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      hist    <= 1'b0;
    end else begin
      sync_q1 <= async_in;
      sync_q2 <= sync_q1;
      if (load_hist || track) hist <= sync_q2;
    end
  end

  assign rise = sync_q2 & ~hist;

endmodule

// File: rtl/div_clk_monitor.sv
// rtl/div_clk_monitor.sv - windowed rising-edge counter with lock/fault FSM for the 3.5x divided clock
module div_clk_monitor
  import div_mon_pkg::*;
#(
  parameter int WIN_CYCLES = WIN_CYCLES_DEF,
  parameter int EXP_EDGES  = EXP_EDGES_DEF,
  parameter int TOL        = TOL_DEF,
  parameter int LOCK_WINS  = LOCK_WINS_DEF,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear_fault,
  input  logic             div_clk_in,
  output logic [CNT_W-1:0] edge_cnt,
  output logic             cnt_valid,
  output logic             locked,
  output logic             fault,
  output logic [1:0]       state
);

  localparam int WIN_W = $clog2(WIN_CYCLES);
  localparam int GR_W  = $clog2(LOCK_WINS + 1);
  localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(WIN_CYCLES - 1);
  localparam logic [GR_W-1:0]  LOCK_LAST = GR_W'(LOCK_WINS - 1);
  localparam logic [CNT_W:0]   EXP_V     = (CNT_W + 1)'(EXP_EDGES);
  localparam logic [CNT_W:0]   TOL_V     = (CNT_W + 1)'(TOL);

  mon_state_t       cur_state, nxt_state;
  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] edge_acc;
  logic [CNT_W-1:0] win_total;
  logic [CNT_W:0]   win_wide;
  logic [CNT_W:0]   win_diff;
  logic [GR_W-1:0]  good_run, good_run_nxt;
  logic             rise, active, win_end, good;
  logic             clr_win, run, load_hist;

  assign active = (cur_state != ST_IDLE);

  clk_edge_sync u_edge_sync (
    .clk       (clk),
    .rst       (rst),
    .async_in  (div_clk_in),
    .load_hist (load_hist),
    .track     (active),
    .rise      (rise)
  );

  // running total including this cycle's rise, saturating at all-ones
  assign win_total = (edge_acc == '1) ? edge_acc : edge_acc + {{(CNT_W-1){1'b0}}, rise};
  assign win_wide  = {1'b0, win_total};
  assign win_diff  = (win_wide >= EXP_V) ? (win_wide - EXP_V) : (EXP_V - win_wide);
  assign good      = (win_diff <= TOL_V);
  assign win_end   = active && (win_cnt == WIN_LAST);

  always_comb begin
    nxt_state    = cur_state;
    good_run_nxt = good_run;
    clr_win      = 1'b0;
    run          = 1'b0;
    load_hist    = 1'b0;
    if (!en) begin
      nxt_state    = ST_IDLE;
      good_run_nxt = '0;
      clr_win      = 1'b1;
    end else if (cur_state == ST_IDLE) begin
      nxt_state    = ST_MEASURE;
      good_run_nxt = '0;
      clr_win      = 1'b1;
      load_hist    = 1'b1;
    end else if (clear_fault && cur_state == ST_FAULT) begin
      nxt_state    = ST_MEASURE;
      good_run_nxt = '0;
      clr_win      = 1'b1;
    end else begin
      run = 1'b1;
      if (win_end) begin
        case (cur_state)
          ST_MEASURE: begin
            if (!good) begin
              good_run_nxt = '0;
            end else if (good_run == LOCK_LAST) begin
              nxt_state    = ST_LOCKED;
              good_run_nxt = '0;
            end else begin
              good_run_nxt = good_run + 1'b1;
            end
          end
          ST_LOCKED: if (!good) nxt_state = ST_FAULT;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur_state <= ST_IDLE;
    else     cur_state <= nxt_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_cnt   <= '0;
      edge_acc  <= '0;
      edge_cnt  <= '0;
      cnt_valid <= 1'b0;
      good_run  <= '0;
    end else begin
      good_run  <= good_run_nxt;
      cnt_valid <= run && win_end;
      if (clr_win) begin
        win_cnt  <= '0;
        edge_acc <= '0;
      end else if (run) begin
        if (win_end) begin
          win_cnt  <= '0;
          edge_acc <= '0;
          edge_cnt <= win_total;
        end else begin
          win_cnt  <= win_cnt + 1'b1;
          edge_acc <= win_total;
        end
      end
    end
  end

  assign state  = cur_state;
  assign locked = (cur_state == ST_LOCKED);
  assign fault  = (cur_state == ST_FAULT);

endmodule

// File: tb/tb_div_clk_monitor.sv
// tb/tb_div_clk_monitor.sv - randomized scoreboard bench for div_clk_monitor
module tb_div_clk_monitor;

  localparam int WIN  = 56;
  localparam int EXP  = 16;
  localparam int TOLR = 1;
  localparam int LOCK = 4;
  localparam int K_IDEAL = 0, K_DIV4 = 1, K_ZERO = 2, K_ONE = 3, K_ALT = 4, K_NOISE = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       clear_fault = 1'b0;
  logic       div_clk_in = 1'b0;
  logic [7:0] edge_cnt;
  logic       cnt_valid;
  logic       locked;
  logic       fault;
  logic [1:0] state;

  div_clk_monitor dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .clear_fault (clear_fault),
    .div_clk_in  (div_clk_in),
    .edge_cnt    (edge_cnt),
    .cnt_valid   (cnt_valid),
    .locked      (locked),
    .fault       (fault),
    .state       (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    int st;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // reference model: input history, rises seen in the current window, status
  bit   dq[$];
  bit   win_r[$];
  int   m_state = 0;
  int   m_cnt = 0;
  int   m_good = 0;
  bit   m_valid = 0;
  int   ph = 0;

  task automatic chk(input string nm, input int act, input int expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  function automatic bit pat(input int kind, input int p);
    logic [6:0] ideal = 7'b1100110;
    logic [3:0] d4    = 4'b1100;
    logic [6:0] alt   = 7'b1001000;
    case (kind)
      K_IDEAL: return ideal[6 - (p % 7)];
      K_DIV4:  return d4[3 - (p % 4)];
      K_ZERO:  return 1'b0;
      K_ONE:   return 1'b1;
      K_ALT:   return alt[6 - (p % 7)];
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // a rise is seen by the counter two input samples after the level change
  function automatic bit seen_rise();
    int n = dq.size();
    bit a = (n >= 2) ? dq[n-2] : 1'b0;
    bit b = (n >= 3) ? dq[n-3] : 1'b0;
    return a & ~b;
  endfunction

  task automatic model_edge(input bit e, input bit c);
    bit r = seen_rise();
    m_valid = 1'b0;
    if (!e) begin
      m_state = 0; m_good = 0; win_r.delete();
    end else if (m_state == 0 || (c && m_state == 3)) begin
      m_state = 1; m_good = 0; win_r.delete();
    end else begin
      win_r.push_back(r);
      if (win_r.size() == WIN) begin
        int total = 0;
        bit ok;
        foreach (win_r[i]) total += int'(win_r[i]);
        if (total > 255) total = 255;
        ok = (total >= EXP - TOLR) && (total <= EXP + TOLR);
        if (m_state == 1) begin
          if (!ok) m_good = 0;
          else begin
            m_good++;
            if (m_good == LOCK) begin m_state = 2; m_good = 0; end
          end
        end else if (m_state == 2 && !ok) begin
          m_state = 3;
        end
        m_cnt   = total;
        m_valid = 1'b1;
        exp_q.push_back('{cnt: total, st: m_state});
        win_r.delete();
      end
    end
  endtask

  task automatic step(input bit d, input bit e, input bit c);
    div_clk_in  = d;
    en          = e;
    clear_fault = c;
    model_edge(e, c);
    @(posedge clk);
    #1;
    dq.push_back(d);
    if (dq.size() > 4) void'(dq.pop_front());
    chk("state", int'(state), m_state);
    chk("cnt_valid", int'(cnt_valid), int'(m_valid));
    chk("edge_cnt_hold", int'(edge_cnt), m_cnt);
    chk("locked", int'(locked), int'(m_state == 2));
    chk("fault", int'(fault), int'(m_state == 3));
  endtask

  task automatic run_cycles(input int n, input int kind, input bit e);
    for (int i = 0; i < n; i++) begin
      step(pat(kind, ph), e, 1'b0);
      ph++;
    end
  endtask

  task automatic run_to_pos(input int p, input int kind);
    int guard = 0;
    while (win_r.size() != p && guard < 200) begin
      run_cycles(1, kind, 1'b1);
      guard++;
    end
    chk("reach_window_pos", win_r.size(), p);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_edge_cnt"}, int'(edge_cnt), 0);
    chk({tag, "_cnt_valid"}, int'(cnt_valid), 0);
    chk({tag, "_locked"}, int'(locked), 0);
    chk({tag, "_fault"}, int'(fault), 0);
    chk({tag, "_state"}, int'(state), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; clear_fault = 1'b0; div_clk_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    m_state = 0; m_cnt = 0; m_good = 0; m_valid = 0;
    dq.delete(); win_r.delete();
  endtask

  task automatic fresh_start(input int kind);
    run_cycles(5, kind, 1'b0);
  endtask

  // scoreboard monitor: compares every cnt_valid pulse with the queued window result
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (!rst && cnt_valid) begin
        if (exp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL sb_unexpected_valid: got edge_cnt %0d, expected no pulse", edge_cnt);
        end else begin
          x = exp_q.pop_front();
          chk("sb_edge_cnt", int'(edge_cnt), x.cnt);
          chk("sb_state", int'(state), x.st);
          chk("sb_locked", int'(locked), int'(x.st == 2));
          chk("sb_fault", int'(fault), int'(x.st == 3));
        end
      end
    end
  end

  initial begin
    ph = int'($urandom_range(0, 27));
    do_reset();
    check_reset_vals("reset");

    // ideal ratio: lock on the 4th window end
    fresh_start(K_IDEAL);
    run_cycles(1 + 4 * WIN - 1, K_IDEAL, 1'b1);
    chk("pre_lock_locked", int'(locked), 0);
    run_cycles(1, K_IDEAL, 1'b1);
    chk("lock_locked", int'(locked), 1);
    chk("lock_edge_cnt", int'(edge_cnt), EXP);
    chk("lock_cnt_valid", int'(cnt_valid), 1);

    // divide-by-4 while locked -> fault, then clear and relock
    run_cycles(2 * WIN, K_DIV4, 1'b1);
    chk("fault_state", int'(state), 3);
    chk("fault_flag", int'(fault), 1);
    chk("fault_locked", int'(locked), 0);
    step(pat(K_IDEAL, ph), 1'b1, 1'b1); ph++;
    chk("clear_state", int'(state), 1);
    chk("clear_fault_flag", int'(fault), 0);
    run_cycles(6 * WIN, K_IDEAL, 1'b1);
    chk("relock", int'(locked), 1);

    // en dropped mid-window while locked
    run_cycles(20, K_IDEAL, 1'b1);
    step(pat(K_IDEAL, ph), 1'b0, 1'b0); ph++;
    chk("en_off_state", int'(state), 0);
    chk("en_off_locked", int'(locked), 0);
    chk("en_off_edge_cnt", int'(edge_cnt), EXP);
    run_cycles(3, K_IDEAL, 1'b0);
    run_cycles(WIN, K_IDEAL, 1'b1);
    chk("reen_no_early_valid", int'(cnt_valid), 0);
    run_cycles(1, K_IDEAL, 1'b1);
    chk("reen_first_valid", int'(cnt_valid), 1);

    // stuck low, then stuck high from a fresh enable
    run_cycles(8, K_ZERO, 1'b0);
    run_cycles(3 * WIN + 1, K_ZERO, 1'b1);
    chk("stuck0_edge_cnt", int'(edge_cnt), 0);
    chk("stuck0_state", int'(state), 1);
    run_cycles(8, K_ONE, 1'b0);
    run_cycles(3 * WIN + 1, K_ONE, 1'b1);
    chk("stuck1_edge_cnt", int'(edge_cnt), 0);
    chk("stuck1_state", int'(state), 1);

    // divide-by-4 never locks; alternating 3/4 periods do
    fresh_start(K_DIV4);
    run_cycles(3 * WIN + 1, K_DIV4, 1'b1);
    chk("div4_edge_cnt", int'(edge_cnt), 14);
    chk("div4_state", int'(state), 1);
    fresh_start(K_ALT);
    run_cycles(4 * WIN + 1, K_ALT, 1'b1);
    chk("alt_edge_cnt", int'(edge_cnt), EXP);
    chk("alt_locked", int'(locked), 1);

    // asynchronous reset at window cycle 30
    run_to_pos(30, K_ALT);
    rst = 1'b1;
    #1;
    check_reset_vals("midwin_rst");
    do_reset();
    check_reset_vals("after_rst");

    // en=0 together with clear_fault on a window end while faulted
    fresh_start(K_IDEAL);
    run_cycles(4 * WIN + 1, K_IDEAL, 1'b1);
    run_cycles(2 * WIN, K_DIV4, 1'b1);
    chk("pre_prio_fault", int'(fault), 1);
    run_to_pos(WIN - 1, K_DIV4);
    step(pat(K_DIV4, ph), 1'b0, 1'b1); ph++;
    chk("prio_no_valid", int'(cnt_valid), 0);
    chk("prio_state", int'(state), 0);
    chk("prio_fault", int'(fault), 0);

    // randomized windows: mixed patterns, enable drops, stray clear pulses
    for (int w = 0; w < 20; w++) begin
      int kind = int'($urandom_range(0, 5));
      for (int i = 0; i < WIN; i++) begin
        bit e = ($urandom_range(0, 299) != 0);
        bit c = ($urandom_range(0, 39) == 0);
        step(pat(kind, ph), e, c);
        ph++;
      end
    end

    @(negedge clk);
    #1;
    chk("sb_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
